fulladd_gate: RTL and testbench

FULLADD_GATE -- requirements
Module: fulladd_gate

---
 rtl/fulladd_gate.sv | 62 ++++++
 tb/tb_fulladd_gate.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fulladd_gate.sv
// fulladd_gate: ripple-carry adder built from gate-level full-adder cells,
// with a live combinational result and a 1-cycle registered copy.
module fulladd_gate #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic [WIDTH-1:0] s_q,
    output logic             cout_q,
    output logic             out_valid
);

    logic [WIDTH-1:0] s_d;
    logic             cout_d;
    logic             out_valid_d;

    // Ripple chain: each iteration is one full-adder cell fed by the previous carry
    always_comb begin
        logic carry;
        logic prop;
        carry = cin;
        prop  = 1'b0;
        s     = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            prop  = a[i] ^ b[i];
            s[i]  = prop ^ carry;
            carry = (a[i] & b[i]) | (carry & prop);
        end
        cout = carry;
    end

    // Next-state for the output registers: capture on in_valid, otherwise hold
    always_comb begin
        s_d         = s_q;
        cout_d      = cout_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            s_d    = s;
            cout_d = cout;
        end
    end

    // Output registers with synchronous active-low reset taking priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q       <= '0;
            cout_q    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            s_q       <= s_d;
            cout_q    <= cout_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fulladd_gate.sv
// Self-checking bench for fulladd_gate at WIDTH = 1, 4 and 8.
module tb_fulladd_gate;

    logic clk;
    logic rst_n;

    logic       a1, b1, cin1, iv1;
    logic       s1, cout1, s_q1, cout_q1, ov1;
    logic [3:0] a4, b4, s4, s_q4;
    logic       cin4, iv4, cout4, cout_q4, ov4;
    logic [7:0] a8, b8, s8, s_q8;
    logic       cin8, iv8, cout8, cout_q8, ov8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       v;
        logic [8:0] sum;
    } rec_t;

    rec_t       sb[$];
    logic [8:0] model8 = 9'd0;

    fulladd_gate #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .in_valid(iv1),
        .s(s1), .cout(cout1), .s_q(s_q1), .cout_q(cout_q1), .out_valid(ov1)
    );

    fulladd_gate #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4), .in_valid(iv4),
        .s(s4), .cout(cout4), .s_q(s_q4), .cout_q(cout_q4), .out_valid(ov4)
    );

    fulladd_gate #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8),
        .s(s8), .cout(cout8), .s_q(s_q8), .cout_q(cout_q8), .out_valid(ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one WIDTH=8 vector, check the live sum, push the expectation, then
    // pop it one edge later and check the registered outputs.
    task automatic step8(input logic v, input logic [7:0] aa, input logic [7:0] bb,
                         input logic cc);
        rec_t r;
        logic [8:0] ref_sum;
        a8 = aa; b8 = bb; cin8 = cc; iv8 = v;
        ref_sum = 9'(aa) + 9'(bb) + 9'(cc);
        sb.push_back('{rst: ~rst_n, v: v, sum: ref_sum});
        #1;
        check("w8_comb", 64'({cout8, s8}), 64'(ref_sum));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("w8_sb_empty", 64'(sb.size()), 64'(1));
        end else begin
            r = sb.pop_front();
            if (r.rst)      model8 = 9'd0;
            else if (r.v)   model8 = r.sum;
            check("w8_s_q",      64'(s_q8),    64'(model8[7:0]));
            check("w8_cout_q",   64'(cout_q8), 64'(model8[8]));
            check("w8_out_valid", 64'(ov8),    64'(r.v & ~r.rst));
        end
    endtask

    logic [1:0] exh_tab [8];

    initial begin
        exh_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; iv1 = 1'b0;
        a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0; iv4 = 1'b0;
        a8 = 8'h0; b8 = 8'h0; cin8 = 1'b0; iv8 = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_q1",  64'(s_q1),   64'(0));
        check("rst_cq1",   64'(cout_q1), 64'(0));
        check("rst_ov1",   64'(ov1),    64'(0));
        check("rst_s_q4",  64'(s_q4),   64'(0));
        check("rst_ov8",   64'(ov8),    64'(0));

        // Exhaustive WIDTH=1, 10 ns per vector (combinational, live in reset)
        for (int v = 0; v < 8; v++) begin
            {a1, b1, cin1} = 3'(v);
            #5;
            check($sformatf("exh_%0d", v), 64'({cout1, s1}), 64'(exh_tab[v]));
            #5;
        end

        // Reset holds registers at 0 with in_valid=1; comb outputs stay live
        @(posedge clk);
        #1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0; iv1 = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rsthold_s_q",  64'(s_q1),   64'(0));
            check("rsthold_cq",   64'(cout_q1), 64'(0));
            check("rsthold_ov",   64'(ov1),    64'(0));
            check("rsthold_s",    64'(s1),     64'(0));
            check("rsthold_cout", 64'(cout1),  64'(1));
        end

        // Latency: one valid cycle, then hold
        rst_n = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; iv1 = 1'b1;
        a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1; iv4 = 1'b1;
        #1;
        check("ripple_s4",    64'(s4),    64'(4'h0));
        check("ripple_cout4", 64'(cout4), 64'(1));
        @(posedge clk);
        #1;
        check("lat_s_q",   64'(s_q1),   64'(1));
        check("lat_cq",    64'(cout_q1), 64'(1));
        check("lat_ov",    64'(ov1),    64'(1));
        check("w4_s_q",    64'(s_q4),   64'(4'h0));
        check("w4_cq",     64'(cout_q4), 64'(1));
        check("w4_ov",     64'(ov4),    64'(1));
        iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        a4 = 4'h7; b4 = 4'h8; cin4 = 1'b0; iv4 = 1'b0;
        #1;
        check("ripple2_s4",    64'(s4),    64'(4'hF));
        check("ripple2_cout4", 64'(cout4), 64'(0));
        @(posedge clk);
        #1;
        check("hold_ov",   64'(ov1),     64'(0));
        check("hold_s_q",  64'(s_q1),    64'(1));
        check("hold_cq",   64'(cout_q1), 64'(1));
        check("hold_s_q4", 64'(s_q4),    64'(4'h0));
        check("hold_ov4",  64'(ov4),     64'(0));

        // Reset mid-stream on WIDTH=8
        step8(1'b1, 8'hFF, 8'h01, 1'b0);
        step8(1'b1, 8'h12, 8'h34, 1'b1);
        step8(1'b0, 8'hAA, 8'h55, 1'b1);
        rst_n = 1'b0;
        step8(1'b1, 8'hC3, 8'h3C, 1'b1);
        rst_n = 1'b1;
        step8(1'b1, 8'h80, 8'h80, 1'b0);
        step8(1'b1, 8'h01, 8'hFE, 1'b1);

        // Random stream WIDTH=8 with random qualifier
        for (int n = 0; n < 1000; n++) begin
            step8(1'($urandom_range(0, 7) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
        end

        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
